// File: rtl/dvp_pkg.sv
// rtl/dvp_pkg.sv - shared state encoding and limits for the DVP pixel capture block
package dvp_pkg;

   localparam int BPP_MAX = 4;

   typedef enum logic [1:0] {
      ST_WAIT_STABLE = 2'd0,
      ST_WAIT_FRAME  = 2'd1,
      ST_IN_FRAME    = 2'd2
   } dvp_state_e;

endpackage

// File: rtl/dvp_byte_packer.sv
// rtl/dvp_byte_packer.sv - assembles BPP camera words into one pixel, first word in the MSBs
module dvp_byte_packer
   import dvp_pkg::*;
#(
   parameter int IN_W = 8,
   parameter int BPP  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                wr,
   input  logic [IN_W-1:0]     wr_data,
   output logic                pix_done,
   output logic [IN_W*BPP-1:0] pix_word,
   output logic                partial
);

   localparam int PW = IN_W * BPP;
   localparam int CW = $clog2(BPP_MAX);
   localparam logic [CW-1:0] LAST = CW'(BPP - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] sr_q, sr_d;

   // pix_word is the shift register with the incoming word appended; valid when pix_done
   assign pix_word = (sr_q << IN_W) | PW'(wr_data);
   assign pix_done = wr && (cnt_q == LAST);
   assign partial  = (cnt_q != '0);

   // Clear drops any partial pixel; otherwise each written word shifts in and advances the count
   always_comb begin
      cnt_d = cnt_q;
      sr_d  = sr_q;
      if (clr) begin
         cnt_d = '0;
         sr_d  = '0;
      end else if (wr) begin
         sr_d  = pix_word;
         cnt_d = pix_done ? '0 : cnt_q + CW'(1);
      end
   end

   // Packer state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         sr_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         sr_q  <= sr_d;
      end
   end

endmodule

// File: rtl/dvp_pixel_capture.sv
// rtl/dvp_pixel_capture.sv - DVP camera capture top; optional crop window with DVP_CROP_EN
module dvp_pixel_capture
   import dvp_pkg::*;
#(
   parameter int IN_W         = 8,
   parameter int BPP          = 2,
   parameter int STABLE_FRAME = 10,
   parameter int H_ACT        = 640,
   parameter int V_ACT        = 480,
   parameter int VS_POL       = 1
) (
   input  logic                       ov5640_pclk,
   input  logic                       rst,
   input  logic                       cam_vsync,
   input  logic                       cam_href,
   input  logic [IN_W-1:0]            cam_data,
`ifdef DVP_CROP_EN
   input  logic [$clog2(H_ACT)-1:0]   crop_x0,
   input  logic [$clog2(V_ACT)-1:0]   crop_y0,
   input  logic [$clog2(H_ACT)-1:0]   crop_w,
   input  logic [$clog2(V_ACT)-1:0]   crop_h,
`endif
   output logic                       pix_valid,
   output logic [IN_W*BPP-1:0]        pix_data,
   output logic [$clog2(H_ACT)-1:0]   pix_x,
   output logic [$clog2(V_ACT)-1:0]   pix_y,
   output logic                       frame_start,
   output logic                       frame_end,
   output logic                       line_err,
   output logic                       frame_err,
   output logic                       frame_valid
);

   localparam int PW  = IN_W * BPP;
   localparam int XW  = $clog2(H_ACT);
   localparam int YW  = $clog2(V_ACT);
   localparam int XCW = $clog2(H_ACT + 2);
   localparam int YCW = $clog2(V_ACT + 2);
   localparam int SCW = $clog2(STABLE_FRAME + 2);
   localparam logic VS_ACT = (VS_POL != 0);
   // Counters saturate one past the active size so overruns stay distinguishable from a good count
   localparam logic [XCW-1:0] X_END = XCW'(H_ACT);
   localparam logic [XCW-1:0] X_SAT = XCW'(H_ACT + 1);
   localparam logic [YCW-1:0] Y_END = YCW'(V_ACT);
   localparam logic [YCW-1:0] Y_SAT = YCW'(V_ACT + 1);
   localparam logic [SCW-1:0] S_END = SCW'(STABLE_FRAME);

   logic            vs_q, vs_d, hr_q, hr_d, vs_prev_q, vs_prev_d, hr_prev_q, hr_prev_d;
   logic [IN_W-1:0] dat_q, dat_d;
   dvp_state_e      state_q, state_d;
   logic [SCW-1:0]  stab_q, stab_d;
   logic [XCW-1:0]  x_q, x_d;
   logic [YCW-1:0]  y_q, y_d;
   logic            first_q, first_d;
   logic            pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
   logic            frame_end_q, frame_end_d, line_err_q, line_err_d;
   logic            frame_err_q, frame_err_d, frame_valid_q, frame_valid_d;
   logic [PW-1:0]   pix_data_q, pix_data_d;
   logic [XW-1:0]   pix_x_q, pix_x_d, rel_x;
   logic [YW-1:0]   pix_y_q, pix_y_d, rel_y;
   logic            vs_edge, hr_fall, in_frame, in_win;
   logic            pk_wr, pk_clr, pk_done, pk_partial;
   logic [PW-1:0]   pk_word;

   assign vs_edge  = (vs_q == VS_ACT) && (vs_prev_q != VS_ACT);
   assign hr_fall  = hr_prev_q && !hr_q;
   assign in_frame = (state_q == ST_IN_FRAME);
   assign pk_wr    = in_frame && hr_q && !vs_edge;
   assign pk_clr   = !in_frame || vs_edge || hr_fall;

   dvp_byte_packer #(.IN_W(IN_W), .BPP(BPP)) u_packer (
      .clk      (ov5640_pclk),
      .rst      (rst),
      .clr      (pk_clr),
      .wr       (pk_wr),
      .wr_data  (dat_q),
      .pix_done (pk_done),
      .pix_word (pk_word),
      .partial  (pk_partial)
   );

`ifdef DVP_CROP_EN
   logic [XW-1:0] cx0_q, cx0_d, cw_q, cw_d;
   logic [YW-1:0] cy0_q, cy0_d, ch_q, ch_d;
   logic [XCW:0]  x_lo, x_hi;
   logic [YCW:0]  y_lo, y_hi;

   assign x_lo   = (XCW+1)'(cx0_q);
   assign x_hi   = x_lo + (XCW+1)'(cw_q);
   assign y_lo   = (YCW+1)'(cy0_q);
   assign y_hi   = y_lo + (YCW+1)'(ch_q);
   assign in_win = ({1'b0, x_q} >= x_lo) && ({1'b0, x_q} < x_hi) &&
                   ({1'b0, y_q} >= y_lo) && ({1'b0, y_q} < y_hi);
   assign rel_x  = XW'(x_q - XCW'(cx0_q));
   assign rel_y  = YW'(y_q - YCW'(cy0_q));

   // Window is taken at each frame boundary so it cannot change mid-frame
   always_comb begin
      cx0_d = vs_edge ? crop_x0 : cx0_q;
      cy0_d = vs_edge ? crop_y0 : cy0_q;
      cw_d  = vs_edge ? crop_w  : cw_q;
      ch_d  = vs_edge ? crop_h  : ch_q;
   end

   // Crop window registers
   always_ff @(posedge ov5640_pclk) begin
      if (rst) begin
         cx0_q <= '0; cy0_q <= '0; cw_q <= '0; ch_q <= '0;
      end else begin
         cx0_q <= cx0_d; cy0_q <= cy0_d; cw_q <= cw_d; ch_q <= ch_d;
      end
   end
`else
   assign in_win = 1'b1;
   assign rel_x  = XW'(x_q);
   assign rel_y  = YW'(y_q);
`endif

   // Frame sequencing, line/frame accounting and next-state for every registered output
   always_comb begin
      vs_d          = cam_vsync;
      hr_d          = cam_href;
      dat_d         = cam_data;
      vs_prev_d     = vs_q;
      hr_prev_d     = hr_q;
      state_d       = state_q;
      stab_d        = stab_q;
      x_d           = x_q;
      y_d           = y_q;
      first_d       = first_q;
      pix_valid_d   = 1'b0;
      pix_data_d    = pix_data_q;
      pix_x_d       = pix_x_q;
      pix_y_d       = pix_y_q;
      frame_start_d = 1'b0;
      frame_end_d   = 1'b0;
      line_err_d    = 1'b0;
      frame_err_d   = 1'b0;
      unique case (state_q)
         ST_WAIT_STABLE: begin
            if (vs_edge) begin
               stab_d = stab_q + SCW'(1);
               if (stab_d >= S_END) state_d = ST_WAIT_FRAME;
            end
         end
         ST_WAIT_FRAME: begin
            if (vs_edge) begin
               state_d = ST_IN_FRAME;
               x_d     = '0;
               y_d     = '0;
               first_d = 1'b1;
            end
         end
         ST_IN_FRAME: begin
            if (vs_edge) begin
               // vsync wins over an open line: the line is abandoned and flagged
               frame_end_d = 1'b1;
               frame_err_d = (y_q != Y_END);
               line_err_d  = hr_q || hr_fall;
               x_d         = '0;
               y_d         = '0;
               first_d     = 1'b1;
            end else if (hr_fall) begin
               line_err_d = pk_partial || (x_q != X_END);
               if ((x_q != '0) && (y_q != Y_SAT)) y_d = y_q + YCW'(1);
               x_d = '0;
            end else if (pk_done) begin
               if (x_q != X_SAT) x_d = x_q + XCW'(1);
               if ((x_q < X_END) && (y_q < Y_END) && in_win) begin
                  pix_valid_d   = 1'b1;
                  pix_data_d    = pk_word;
                  pix_x_d       = rel_x;
                  pix_y_d       = rel_y;
                  frame_start_d = first_q;
                  first_d       = 1'b0;
               end
            end
         end
         default: state_d = ST_WAIT_STABLE;
      endcase
      frame_valid_d = (state_d == ST_IN_FRAME);
   end

   // All state and outputs registered; reset aborts any frame silently
   always_ff @(posedge ov5640_pclk) begin
      if (rst) begin
         vs_q <= 1'b0; hr_q <= 1'b0; dat_q <= '0; vs_prev_q <= 1'b0; hr_prev_q <= 1'b0;
         state_q <= ST_WAIT_STABLE; stab_q <= '0; x_q <= '0; y_q <= '0; first_q <= 1'b0;
         pix_valid_q <= 1'b0; pix_data_q <= '0; pix_x_q <= '0; pix_y_q <= '0;
         frame_start_q <= 1'b0; frame_end_q <= 1'b0; line_err_q <= 1'b0;
         frame_err_q <= 1'b0; frame_valid_q <= 1'b0;
      end else begin
         vs_q <= vs_d; hr_q <= hr_d; dat_q <= dat_d; vs_prev_q <= vs_prev_d; hr_prev_q <= hr_prev_d;
         state_q <= state_d; stab_q <= stab_d; x_q <= x_d; y_q <= y_d; first_q <= first_d;
         pix_valid_q <= pix_valid_d; pix_data_q <= pix_data_d; pix_x_q <= pix_x_d; pix_y_q <= pix_y_d;
         frame_start_q <= frame_start_d; frame_end_q <= frame_end_d; line_err_q <= line_err_d;
         frame_err_q <= frame_err_d; frame_valid_q <= frame_valid_d;
      end
   end

   assign pix_valid   = pix_valid_q;
   assign pix_data    = pix_data_q;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign frame_start = frame_start_q;
   assign frame_end   = frame_end_q;
   assign line_err    = line_err_q;
   assign frame_err   = frame_err_q;
   assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_dvp_pixel_capture.sv
// tb/tb_dvp_pixel_capture.sv - directed self-checking bench for dvp_pixel_capture
module tb_dvp_pixel_capture;

`ifdef DVP_CROP_EN
   localparam int H_ACT = 8;
   localparam int V_ACT = 4;
`else
   localparam int H_ACT = 4;
   localparam int V_ACT = 2;
`endif
   localparam int XW = $clog2(H_ACT);
   localparam int YW = $clog2(V_ACT);

   logic          clk = 1'b0;
   logic          rst, cam_vsync, cam_href;
   logic [7:0]    cam_data;
   logic          pix_valid, frame_start, frame_end, line_err, frame_err, frame_valid;
   logic [15:0]   pix_data;
   logic [XW-1:0] pix_x;
   logic [YW-1:0] pix_y;
`ifdef DVP_CROP_EN
   logic [XW-1:0] crop_x0, crop_w;
   logic [YW-1:0] crop_y0, crop_h;
`endif

   int checks = 0;
   int errors = 0;
   int n_fe = 0, n_le = 0, n_ferr = 0, n_fe_ferr = 0, n_fs = 0;
   logic [15:0]   pd_log[$];
   logic [XW-1:0] px_log[$];
   logic [YW-1:0] py_log[$];
   logic [15:0]   fs_data = '0;

   always #5 clk = ~clk;

   dvp_pixel_capture #(
      .IN_W(8), .BPP(2), .STABLE_FRAME(10), .H_ACT(H_ACT), .V_ACT(V_ACT), .VS_POL(1)
   ) dut (
      .ov5640_pclk (clk),
      .rst         (rst),
      .cam_vsync   (cam_vsync),
      .cam_href    (cam_href),
      .cam_data    (cam_data),
`ifdef DVP_CROP_EN
      .crop_x0     (crop_x0),
      .crop_y0     (crop_y0),
      .crop_w      (crop_w),
      .crop_h      (crop_h),
`endif
      .pix_valid   (pix_valid),
      .pix_data    (pix_data),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .frame_start (frame_start),
      .frame_end   (frame_end),
      .line_err    (line_err),
      .frame_err   (frame_err),
      .frame_valid (frame_valid)
   );

   // Mid-cycle observer logging pixels and pulse counts
   always @(negedge clk) begin
      if (pix_valid) begin
         pd_log.push_back(pix_data);
         px_log.push_back(pix_x);
         py_log.push_back(pix_y);
      end
      if (frame_start) begin
         n_fs++;
         fs_data = pix_data;
      end
      if (frame_end) n_fe++;
      if (line_err) n_le++;
      if (frame_err) n_ferr++;
      if (frame_end && frame_err) n_fe_ferr++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_vsync();
      cam_vsync = 1'b1;
      tick(); tick();
      cam_vsync = 1'b0;
      tick(); tick();
   endtask

   task automatic send_line(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         cam_href = 1'b1;
         cam_data = base + 8'(i);
         tick();
      end
      cam_href = 1'b0;
      cam_data = 8'h00;
      repeat (4) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
      repeat (3) tick();
      checks++;
      if ({pix_valid, frame_start, frame_end, line_err, frame_err, frame_valid} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags got %b expected 000000",
                  {pix_valid, frame_start, frame_end, line_err, frame_err, frame_valid});
      end
      checks++;
      if (pix_data !== 16'h0000) begin errors++; $display("FAIL reset_pix_data got %h expected 0000", pix_data); end
      checks++;
      if ({pix_x, pix_y} !== '0) begin errors++; $display("FAIL reset_coords got x=%0d y=%0d expected 0,0", pix_x, pix_y); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_stable();
      int p0, fe0, le0;
      logic fv_seen;
      p0 = pd_log.size(); fe0 = n_fe; le0 = n_le; fv_seen = 1'b0;
      for (int f = 0; f < 10; f++) begin
         send_vsync();
         if (frame_valid) fv_seen = 1'b1;
         send_line(2 * H_ACT, 8'h40);
      end
      checks++;
      if (fv_seen !== 1'b0 || frame_valid !== 1'b0) begin
         errors++; $display("FAIL stable_frame_valid got %b expected 0", fv_seen | frame_valid);
      end
      checks++;
      if (pd_log.size() - p0 != 0) begin errors++; $display("FAIL stable_no_pix got %0d expected 0", pd_log.size() - p0); end
      checks++;
      if (n_le - le0 != 0) begin errors++; $display("FAIL stable_no_line_err got %0d expected 0", n_le - le0); end
      send_vsync();
      checks++;
      if (frame_valid !== 1'b1) begin errors++; $display("FAIL stable_11th_edge got %b expected 1", frame_valid); end
      checks++;
      if (n_fe - fe0 != 0) begin errors++; $display("FAIL stable_no_frame_end got %0d expected 0", n_fe - fe0); end
   endtask

   task automatic test_packing();
      logic [7:0] pk [8];
      int p0, le0, fe0, fr0;
      pk = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
      p0 = pd_log.size(); le0 = n_le; fe0 = n_fe; fr0 = n_ferr;
      for (int i = 0; i <= 8; i++) begin
         cam_href = (i < 8);
         cam_data = (i < 8) ? pk[i] : 8'h00;
         tick();
         if (i == 2) begin
            checks++;
            if ({pix_valid, frame_start, pix_data, 2'(pix_x)} !== {1'b1, 1'b1, 16'h1234, 2'd0}) begin
               errors++; $display("FAIL pack_first got v=%b fs=%b d=%h x=%0d expected 1 1 1234 0",
                                  pix_valid, frame_start, pix_data, pix_x);
            end
         end
         if (i == 3) begin
            checks++;
            if ({pix_valid, pix_data} !== {1'b0, 16'h1234}) begin
               errors++; $display("FAIL pack_hold got v=%b d=%h expected 0 1234", pix_valid, pix_data);
            end
         end
         if (i == 4) begin
            checks++;
            if ({pix_valid, frame_start, pix_data, 2'(pix_x)} !== {1'b1, 1'b0, 16'h5678, 2'd1}) begin
               errors++; $display("FAIL pack_second got v=%b fs=%b d=%h x=%0d expected 1 0 5678 1",
                                  pix_valid, frame_start, pix_data, pix_x);
            end
         end
      end
      repeat (4) tick();
      checks++;
      if (pd_log.size() - p0 != 4 || pd_log[pd_log.size()-1] !== 16'hDEF0) begin
         errors++; $display("FAIL pack_line_count got %0d expected 4", pd_log.size() - p0);
      end
      send_line(8, 8'h20);
      checks++;
      if (py_log[py_log.size()-1] !== YW'(1)) begin
         errors++; $display("FAIL pack_second_line_y got %0d expected 1", py_log[py_log.size()-1]);
      end
      send_vsync();
      checks++;
      if (n_fe - fe0 != 1 || n_ferr - fr0 != 0 || n_le - le0 != 0) begin
         errors++; $display("FAIL good_frame_end got fe=%0d ferr=%0d le=%0d expected 1 0 0",
                            n_fe - fe0, n_ferr - fr0, n_le - le0);
      end
   endtask

   task automatic test_short_line();
      int p0, le0;
      p0 = pd_log.size(); le0 = n_le;
      send_line(7, 8'h60);
      checks++;
      if (pd_log.size() - p0 != 3) begin errors++; $display("FAIL short_pix_count got %0d expected 3", pd_log.size() - p0); end
      checks++;
      if (n_le - le0 != 1) begin errors++; $display("FAIL short_line_err got %0d expected 1", n_le - le0); end
      send_line(8, 8'h70);
      checks++;
      if (pd_log.size() - p0 != 7 || px_log[p0+3] !== XW'(0) || py_log[p0+3] !== YW'(1) ||
          pd_log[p0+3] !== 16'h7071) begin
         errors++; $display("FAIL next_line_start got x=%0d y=%0d d=%h expected 0 1 7071",
                            px_log[p0+3], py_log[p0+3], pd_log[p0+3]);
      end
   endtask

   task automatic test_line_mismatch();
      int p0, le0, fe0, ff0;
      p0 = pd_log.size(); le0 = n_le; fe0 = n_fe; ff0 = n_fe_ferr;
      send_line(8, 8'h80);
      checks++;
      if (pd_log.size() - p0 != 0) begin errors++; $display("FAIL extra_line_suppressed got %0d expected 0", pd_log.size() - p0); end
      send_vsync();
      checks++;
      if (n_fe - fe0 != 1 || n_fe_ferr - ff0 != 1) begin
         errors++; $display("FAIL frame_err_with_end got fe=%0d both=%0d expected 1 1", n_fe - fe0, n_fe_ferr - ff0);
      end
      checks++;
      if (n_le - le0 != 0) begin errors++; $display("FAIL mismatch_line_err got %0d expected 0", n_le - le0); end
   endtask

   task automatic test_reset_mid_frame();
      int fe0, p0;
      cam_href = 1'b1;
      cam_data = 8'hAA; tick();
      cam_data = 8'hBB; tick();
      cam_data = 8'hCC; tick();
      checks++;
      if (pix_data !== 16'hAABB || pix_y !== YW'(0)) begin
         errors++; $display("FAIL pre_reset_pixel got %h expected aabb", pix_data);
      end
      fe0 = n_fe;
      rst = 1'b1;
      tick();
      checks++;
      if ({pix_valid, frame_start, frame_end, line_err, frame_err, frame_valid} !== 6'b0 ||
          pix_data !== 16'h0000 || {pix_x, pix_y} !== '0) begin
         errors++; $display("FAIL midreset_outputs got d=%h fv=%b expected 0000 0", pix_data, frame_valid);
      end
      rst = 1'b0;
      cam_data = 8'hDD; tick();
      cam_href = 1'b0; cam_data = 8'h00;
      repeat (4) tick();
      p0 = pd_log.size();
      repeat (10) begin
         send_vsync();
         send_line(8, 8'h90);
      end
      checks++;
      if (frame_valid !== 1'b0 || pd_log.size() - p0 != 0) begin
         errors++; $display("FAIL midreset_rewait got fv=%b pix=%0d expected 0 0", frame_valid, pd_log.size() - p0);
      end
      send_vsync();
      checks++;
      if (frame_valid !== 1'b1) begin errors++; $display("FAIL midreset_reenable got %b expected 1", frame_valid); end
      checks++;
      if (n_fe - fe0 != 0) begin errors++; $display("FAIL midreset_no_frame_end got %0d expected 0", n_fe - fe0); end
   endtask

`ifdef DVP_CROP_EN
   task automatic test_crop();
      int p0, fs0, le0, fr0;
      p0 = pd_log.size(); fs0 = n_fs; le0 = n_le; fr0 = n_ferr;
      for (int y = 0; y < 4; y++) begin
         for (int i = 0; i < 16; i++) begin
            cam_href = 1'b1;
            cam_data = (i % 2 == 1) ? 8'h55 : {4'(y), 4'(i / 2)};
            tick();
         end
         cam_href = 1'b0; cam_data = 8'h00;
         repeat (4) tick();
      end
      send_vsync();
      checks++;
      if (pd_log.size() - p0 != 6) begin errors++; $display("FAIL crop_count got %0d expected 6", pd_log.size() - p0); end
      for (int k = 0; k < 6; k++) begin
         if (p0 + k < pd_log.size()) begin
            checks++;
            if (px_log[p0+k] !== XW'(k % 3) || py_log[p0+k] !== YW'(k / 3)) begin
               errors++; $display("FAIL crop_coord%0d got %0d,%0d expected %0d,%0d",
                                  k, px_log[p0+k], py_log[p0+k], k % 3, k / 3);
            end
         end
      end
      checks++;
      if (n_fs - fs0 != 1 || fs_data !== 16'h1255) begin
         errors++; $display("FAIL crop_frame_start got n=%0d d=%h expected 1 1255", n_fs - fs0, fs_data);
      end
      checks++;
      if (n_le - le0 != 0 || n_ferr - fr0 != 0) begin
         errors++; $display("FAIL crop_errors got le=%0d fe=%0d expected 0 0", n_le - le0, n_ferr - fr0);
      end
   endtask
`endif

   initial begin
`ifdef DVP_CROP_EN
      crop_x0 = XW'(2); crop_y0 = YW'(1); crop_w = XW'(3); crop_h = YW'(2);
      test_reset();
      test_stable();
      test_crop();
`else
      test_reset();
      test_stable();
      test_packing();
      test_short_line();
      test_line_mismatch();
      test_reset_mid_frame();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dvp_pixel_capture.md
DVP_PIXEL_CAPTURE -- requirements
Module: dvp_pixel_capture

Interface
REQ-001 Parameter IN_W, default 8, sets the camera data bus width in bits.
REQ-002 Parameter BPP, default 2, sets bytes (IN_W-bit words) per pixel; legal range 1..4.
REQ-003 Parameter STABLE_FRAME, default 10, sets the number of frames discarded after reset.
REQ-004 Parameter H_ACT, default 640, sets the expected pixels per line.
REQ-005 Parameter V_ACT, default 480, sets the expected lines per frame.
REQ-006 Parameter VS_POL, default 1, sets the vsync active level.
REQ-007 Ports SHALL be as follows, clock and reset first:
- ov5640_pclk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cam_vsync  in  1  camera vertical sync.
- cam_href  in  1  camera line valid.
- cam_data  in  IN_W  camera data.
- pix_valid  out  1  pixel strobe.
- pix_data  out  IN_W*BPP  assembled pixel, first byte in the MSBs.
- pix_x  out  $clog2(H_ACT)  column of the current pixel.
- pix_y  out  $clog2(V_ACT)  row of the current pixel.
- frame_start  out  1  pulse coincident with the first pix_valid of a frame.
- frame_end  out  1  pulse at the vsync active edge that closes a frame.
- line_err  out  1  pulse on a malformed line.
- frame_err  out  1  pulse on a line-count mismatch.
- frame_valid  out  1  level; high once capture is enabled.

Function
REQ-008 Register cam_vsync, cam_href and cam_data once on input; all decisions use the registered copies.
REQ-009 Vsync active edge: registered vsync goes from not-VS_POL to VS_POL.
REQ-010 FSM states and transitions:
- WAIT_STABLE: counts vsync active edges; reaching STABLE_FRAME moves to WAIT_FRAME.
- WAIT_FRAME: the next vsync active edge moves to IN_FRAME.
- IN_FRAME: stays until reset.
REQ-011 frame_valid SHALL be high only in IN_FRAME.
REQ-012 In IN_FRAME, each registered href-high cycle captures one word; a byte counter wraps 0..BPP-1.
REQ-013 pix_valid SHALL pulse for one cycle, registered, in the cycle after the BPP-th word is registered (2-cycle latency from cam_data sampling).
REQ-014 pix_data, pix_x and pix_y SHALL hold their values until the next pix_valid.
REQ-015 pix_x increments per pixel and clears at href fall; pix_y increments at each href fall that carried at least 1 pixel; both clear at the vsync active edge.
REQ-016 At href fall, a nonzero byte counter (partial pixel) SHALL discard the partial pixel, clear the byte counter and pulse line_err.
REQ-017 At href fall, a pixel count other than H_ACT SHALL pulse line_err; a partial pixel plus a count mismatch still produces a single pulse.
REQ-018 At a vsync active edge in IN_FRAME, a line count other than V_ACT SHALL pulse frame_err in the same cycle as frame_end.
REQ-019 Pixels beyond H_ACT or lines beyond V_ACT SHALL be suppressed (no pix_valid) and saturate their counters; the error is reported at the line or frame end.
REQ-020 If href is high at a vsync active edge, the vsync edge takes priority: the line is abandoned, counters clear, and line_err pulses.
REQ-021 Outside IN_FRAME, pix_valid, frame_start, frame_end, line_err and frame_err SHALL stay 0.

Reset
REQ-022 When rst is high at a clock edge, the block SHALL enter WAIT_STABLE, clear all counters and input registers, and drive every output to 0, including pix_data.
REQ-023 Reset asserted mid-frame SHALL abort the frame without a frame_end pulse and restart the STABLE_FRAME wait.

Configuration
REQ-024 With DVP_CROP_EN defined, the block SHALL add input ports crop_x0, crop_y0, crop_w and crop_h, each the width of the matching coordinate.
REQ-025 With DVP_CROP_EN defined, the crop ports SHALL be sampled at each vsync active edge and held for the frame.
REQ-026 With DVP_CROP_EN defined, pix_valid SHALL assert only inside the window, and pix_x/pix_y SHALL be window-relative.
REQ-027 With DVP_CROP_EN defined, frame_start SHALL mark the first in-window pixel, while error checks still use the full H_ACT/V_ACT.
REQ-028 Without DVP_CROP_EN, the crop ports SHALL be absent and the full frame is output.

Structure
REQ-029 Package dvp_pkg SHALL hold the FSM state enum and the BPP_MAX=4 constant.
REQ-030 Sub-module dvp_byte_packer SHALL perform word-to-pixel assembly: byte counter, shift register and partial-pixel flag.

Verification
REQ-031 Stable wait: 10 vsync pulses after reset -> frame_valid stays 0 and pix_valid never asserts; the 11th vsync active edge -> frame_valid=1.
REQ-032 Packing: BPP=2, href carries 0x12,0x34,0x56,0x78 -> pix_data=0x1234 at pix_x=0, then 0x5678 at pix_x=1, each 2 cycles after its last byte.
REQ-033 Short line: H_ACT=4, href carries 7 words with BPP=2 -> 3 pixels, then 1 line_err pulse at href fall; the next line starts at pix_x=0.
REQ-034 Line mismatch: V_ACT=2, 3 lines then a vsync edge -> frame_end and frame_err in the same cycle, and the third line produces no pix_valid.
REQ-035 Reset mid-frame: rst for 1 cycle during a line -> all outputs 0 next cycle, no frame_end, and 10 further frames required before frame_valid.
REQ-036 Crop (DVP_CROP_EN): 8x4 frame, window x0=2, y0=1, w=3, h=2 -> exactly 6 pix_valid with pix_x 0..2, pix_y 0..1, and frame_start at source (2,1).
